// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
// Shared constants and helpers for the 7-segment scan controller.
//   ANODE_OFF        : all anodes disabled (active-low, so all ones); slice to width
//   DEF_*            : default parameter values for seg_scan_ctrl
//   clog2()          : bits needed to hold the values 0..n-1 (minimum 1)
package seg_scan_pkg;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_DEAD_CYCLES = 2;

  // Wide enough for the largest supported bank (8 digits).
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// seg_scan_prescaler
// Divides clk into digit slots of REFRESH_DIV cycles.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   o_slot_first   : counter is on the first cycle of a slot (count == 0)
//   o_dead         : counter is inside the leading dead window (count < DEAD_CYCLES)
//   o_slot_last    : counter is on the last cycle of a slot (terminal count)
module seg_scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic o_slot_first,
  output logic o_dead,
  output logic o_slot_last
);

  localparam int CW = clog2(REFRESH_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_slot_first = (r_cnt == '0);
  assign o_dead       = (r_cnt < CW'(DEAD_CYCLES));
  assign o_slot_last  = w_term;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for common-anode 7-segment digits that share
// one external bin_7seg decoder. New digit values are double-buffered and only
// applied when the scan wraps back to digit 0, so a frame never mixes old and
// new data.
// Optional build macro: SEG_SCAN_LEADING_ZERO_BLANK_EN
//   When defined, digit k >= 1 is also blanked when it and every higher digit
//   of the displayed value are zero. Digit 0 is never auto-blanked.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   digits_in    : new nibbles, digit 0 in bits [3:0]
//   blank_in     : per-digit blank requests, captured with digits_in
//   digits_wr    : one-cycle write strobe for digits_in/blank_in
//   bi_digit     : nibble for the shared decoder (registered)
//   an           : active-low anode enables (registered, at most one low)
//   upd_pending  : a written value is waiting for the next frame boundary
//   frame_start  : one-cycle pulse when the scan wraps to digit 0
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    digits_wr,
  output logic [3:0]              bi_digit,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    upd_pending,
  output logic                    frame_start
);

  localparam int IW = clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic                    w_slot_first;
  logic                    w_dead;
  logic                    w_slot_last;
  logic                    w_wrap;

  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [4*NUM_DIGITS-1:0] r_pend_d;
  logic [NUM_DIGITS-1:0]   r_pend_b;
  logic                    r_pend_v;

  logic [3:0]              r_bi;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic [3:0]              w_nib;
  logic                    w_blank_sel;
  logic [NUM_DIGITS-1:0]   w_an_on;
  logic [NUM_DIGITS-1:0]   w_auto;
  logic [NUM_DIGITS-1:0]   w_blank_eff;

  seg_scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .o_slot_first (w_slot_first),
    .o_dead       (w_dead),
    .o_slot_last  (w_slot_last)
  );

  // Frame boundary: last cycle of the last digit's slot.
  assign w_wrap = w_slot_last && (r_idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_slot_last) begin
      r_idx <= w_wrap ? '0 : r_idx + IW'(1);
    end
  end

  // Double buffer. A write coinciding with the boundary still lands in pending
  // while the previous pending value moves to the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp   <= '0;
      r_blank  <= '0;
      r_pend_d <= '0;
      r_pend_b <= '0;
      r_pend_v <= 1'b0;
    end else begin
      if (w_wrap && r_pend_v) begin
        r_disp  <= r_pend_d;
        r_blank <= r_pend_b;
      end
      if (digits_wr) begin
        r_pend_d <= digits_in;
        r_pend_b <= blank_in;
        r_pend_v <= 1'b1;
      end else if (w_wrap) begin
        r_pend_v <= 1'b0;
      end
    end
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a digit is auto-blanked while everything
  // from it upward is zero.
  always_comb begin
    logic v_zero_above;
    w_auto       = '0;
    v_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero_above = v_zero_above && (r_disp[4*k +: 4] == 4'd0);
      w_auto[k]    = v_zero_above;
    end
  end
`else
  assign w_auto = '0;
`endif

  assign w_blank_eff = r_blank | w_auto;

  // Select the current digit's nibble, blank flag and anode pattern.
  always_comb begin
    w_nib       = 4'd0;
    w_blank_sel = 1'b0;
    w_an_on     = AN_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib       = r_disp[4*k +: 4];
        w_blank_sel = w_blank_eff[k];
        w_an_on[k]  = 1'b0;
      end
    end
  end

  // Output registers lag the internal slot state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bi          <= 4'd0;
      r_an          <= AN_OFF;
      r_frame_start <= 1'b0;
    end else begin
      if (w_slot_first) begin
        r_bi <= w_nib;
      end
      r_an          <= (w_dead || w_blank_sel) ? AN_OFF : w_an_on;
      r_frame_start <= w_wrap;
    end
  end

  assign bi_digit    = r_bi;
  assign an          = r_an;
  assign upd_pending = r_pend_v;
  assign frame_start = r_frame_start;

endmodule
